// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes and FSM state encoding.
package lsu_pkg;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10,
        SzBad  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StResp  = 2'b11
    } lsu_state_e;

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offs);
        return (size == SzBad) || ((size == SzHalf) && offs[0]) ||
               ((size == SzWord) && (offs != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and memory-side signal bundle of the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: load extract/extend and store merge into the old word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offs_i,
    input  lsu_size_e   size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  bit_offs;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign bit_offs = {offs_i, 3'b000};
    assign byte_sel = word_i[bit_offs +: 8];
    assign half_sel = offs_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_o  = word_i;
        merge_o = word_i;
        case (size_i)
            SzByte: begin
                load_o                  = {{24{signed_i & byte_sel[7]}}, byte_sel};
                merge_o[bit_offs +: 8]  = wdata_i[7:0];
            end
            SzHalf: begin
                load_o = {{16{signed_i & half_sel[15]}}, half_sel};
                if (offs_i[1]) merge_o[31:16] = wdata_i[15:0];
                else           merge_o[15:0]  = wdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed memory with req/resp handshake.
// Define LSU_BOUNDS_CHECK_EN to flag addresses beyond the attached memory as errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MemDepth = 64,
    parameter int unsigned MemAw    = $clog2(MemDepth)
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_e         state_q, state_d;
    logic [MemAw+1:0]   addr_q, addr_d;
    lsu_size_e          size_q, size_d;
    logic               signed_q, signed_d;
    logic               write_q, write_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               accept;
    logic               req_err;
    lsu_size_e          req_size;
    logic [31:0]        lane_load;
    logic [31:0]        lane_merge;

    assign req_size = lsu_size_e'(bus.req_size);
    assign accept   = bus.req_valid && bus.req_ready;

`ifdef LSU_BOUNDS_CHECK_EN
    assign req_err = lsu_misaligned(bus.req_size, bus.req_addr[1:0]) ||
                     (bus.req_addr[31:MemAw+2] != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:MemAw+2];
    assign req_err = lsu_misaligned(bus.req_size, bus.req_addr[1:0]);
`endif

    lsu_byte_lane u_lane (
        .word_i   (bus.mem_rdata),
        .offs_i   (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .load_o   (lane_load),
        .merge_o  (lane_merge)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        // Strobes are decoded from state alone so an async reset kills them at once.
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        bus.mem_read   = (state_q == StRead);
        bus.mem_write  = (state_q == StWrite);
        bus.mem_wdata  = wdata_q;
        bus.mem_addr   = {{(32 - MemAw){1'b0}}, addr_q[MemAw+1:2]};
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d   = bus.req_addr[MemAw+1:0];
                    size_d   = req_size;
                    signed_d = bus.req_signed;
                    write_d  = bus.req_write;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err)                                   state_d = StResp;
                    else if (bus.req_write && req_size == SzWord)  state_d = StWrite;
                    else                                           state_d = StRead;
                end
            end
            StRead: begin
                // Sub-word stores read the old word here and write the merge next cycle.
                if (write_q) begin
                    wdata_d = lane_merge;
                    state_d = StWrite;
                end else begin
                    rdata_d = lane_load;
                    state_d = StResp;
                end
            end
            StWrite: state_d = StResp;
            StResp: begin
                if (bus.resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            size_q   <= SzByte;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level memory/result model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus ();

    load_store_unit #(.MemDepth(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
    always @(posedge clk) begin
        if (pl_en)              mem[pl_idx] <= pl_data;
        else if (bus.mem_write) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: result, latency, write count, memory update.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd,
                                  output int lat, output int nwr);
        logic [31:0] word, v, mask;
        int sh;
        word = ref_mem[a[7:2]];
        sh   = 8 * int'(a[1:0]);
        err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0);
`ifdef LSU_BOUNDS_CHECK_EN
        if ((a >> 8) != 0) err = 1'b1;
`endif
        rd = 0; lat = 1; nwr = 0;
        if (err) return;
        if (!wr) begin
            lat = 2;
            if (sz == 2'b00) begin
                v = (word >> sh) & 32'hFF;
                if (sg && v >= 128) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                v = (word >> sh) & 32'hFFFF;
                if (sg && v >= 32768) v = v | 32'hFFFF_0000;
            end else begin
                v = word;
            end
            rd = v;
        end else begin
            nwr  = 1;
            lat  = (sz == 2'b10) ? 2 : 3;
            mask = (sz == 2'b00) ? (32'hFF << sh) : (sz == 2'b01) ? (32'hFFFF << sh) : '1;
            ref_mem[a[7:2]] = (word & ~mask) | ((wd << sh) & mask);
        end
    endfunction

    bit          txn_active = 0;
    int          cyc, exp_lat, exp_nwr, wr_cnt, hold;
    logic [31:0] exp_rd, lit_rd;
    logic        exp_err, lit_err;
    bit          lit_en;
    logic [5:0]  exp_idx;

    always @(negedge clk) begin
        if (txn_active) begin
            cyc = cyc + 1;
            if (cyc > exp_lat + hold) begin
                chk("done_req_ready", bus.req_ready, 1);
                chk("done_resp_valid", bus.resp_valid, 0);
                chk("write_count", wr_cnt, exp_nwr);
                chk("mem_word", mem[exp_idx], ref_mem[exp_idx]);
                bus.resp_ready = 1'b0;
                txn_active = 0;
            end else begin
                chk("busy_req_ready", bus.req_ready, 0);
                chk("resp_valid", bus.resp_valid, cyc >= exp_lat);
                if (bus.mem_write) begin
                    wr_cnt++;
                    chk("write_cycle", cyc, exp_lat - 1);
                end
                if (cyc >= exp_lat) begin
                    chk("resp_rdata", bus.resp_rdata, exp_rd);
                    chk("resp_err", bus.resp_err, exp_err);
                    if (lit_en && cyc == exp_lat) begin
                        chk("lit_rdata", bus.resp_rdata, lit_rd);
                        chk("lit_err", bus.resp_err, lit_err);
                    end
                end
                if (cyc == exp_lat + hold) bus.resp_ready = 1'b1;
            end
        end else if (rst) begin
            chk("idle_mem_write", bus.mem_write, 0);
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        ref_mem[idx] = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int h,
                       input bit le, input logic [31:0] lr, input logic lerr);
        @(negedge clk);
        chk("idle_req_ready", bus.req_ready, 1);
        model(wr, sz, sg, a, wd, exp_err, exp_rd, exp_lat, exp_nwr);
        exp_idx = a[7:2];
        hold = h; lit_en = le; lit_rd = lr; lit_err = lerr;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 0; wr_cnt = 0;
        txn_active = 1;
        wait (!txn_active);
    endtask

    initial begin
        logic        wr, sg;
        logic [1:0]  sz;
        logic [31:0] a;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b0;

        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        @(negedge clk); rst = 1'b1;

        preload(6'd5, 32'h8877_6655);
        preload(6'd3, 32'h1122_3344);
        txn(0, 2'b00, 1, 32'h17, 0, 0, 1, 32'hFFFF_FF88, 0);
        txn(0, 2'b01, 0, 32'h14, 0, 0, 1, 32'h0000_6655, 0);
        txn(0, 2'b01, 1, 32'h16, 0, 0, 1, 32'hFFFF_8877, 0);
        txn(1, 2'b00, 0, 32'h0D, 32'h0000_00AB, 0, 1, 32'h0, 0);
        chk("sb_word3", mem[3], 32'h1122_AB44);
        txn(1, 2'b10, 0, 32'h02, 32'hDEAD_BEEF, 0, 1, 32'h0, 1);
        chk("misaligned_no_write", mem[0], ref_mem[0]);
        txn(0, 2'b11, 0, 32'h10, 0, 0, 1, 32'h0, 1);
        txn(0, 2'b10, 0, 32'h14, 0, 4, 1, 32'h8877_6655, 0);

        // Reset while the sub-word store is in its write cycle.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0C; bus.req_wdata = 32'h55;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_write", bus.mem_write, 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_mem_write", bus.mem_write, 0);
        chk("midrst_resp_valid", bus.resp_valid, 0);
        chk("midrst_resp_err", bus.resp_err, 0);
        chk("midrst_resp_rdata", bus.resp_rdata, 0);
        chk("midrst_mem_read", bus.mem_read, 0);
        @(posedge clk); #1;
        chk("midrst_no_write", mem[3], 32'h1122_AB44);
        @(negedge clk); rst = 1'b1;

`ifdef LSU_BOUNDS_CHECK_EN
        txn(0, 2'b10, 0, 32'h100, 0, 0, 1, 32'h0, 1);
`else
        txn(0, 2'b10, 0, 32'h100, 0, 0, 0, 32'h0, 0);
`endif

        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom);
            txn(wr, sz, sg, a, $urandom, $urandom_range(0, 3), 0, 32'h0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
